// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU dispatch types and constants
package alu_pkg;

    localparam logic [6:0] CUSTOM0_OPCODE = 7'b0001011;

    typedef enum logic [3:0] {
        OP_ADD      = 4'b0000,
        OP_SUB      = 4'b0001,
        OP_AND      = 4'b0010,
        OP_OR       = 4'b0011,
        OP_POPCOUNT = 4'b0100,
        OP_CLZ      = 4'b0101,
        OP_ILLEGAL  = 4'b1111
    } alu_op_e;

    typedef struct packed {
        alu_op_e     op_code;
        logic [31:0] operand_a;
        logic [31:0] operand_b;
        logic [4:0]  rd;
        logic        illegal;
    } alu_entry_t;

endpackage

// File: rtl/alu_dispatch_fifo.sv
// rtl/alu_dispatch_fifo.sv - in-order buffer of decoded ALU entries
module alu_dispatch_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  alu_entry_t s_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output alu_entry_t m_tdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    alu_entry_t    mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    // Both handshakes depend only on the registered count, so ready never sees out_ready.
    assign s_tready = (count_q < FULL);
    assign m_tvalid = (count_q != '0);
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;
    assign m_tdata  = m_tvalid ? mem_q[rptr_q] : '0;

    always_comb begin
        wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= s_tdata;
        end
    end

endmodule

// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - custom-0 ALU decode and dispatch buffer
// Optional perf counters enabled by ALU_DISPATCH_PERF_EN.
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] operand_a,
    output logic [31:0] operand_b,
    output logic [3:0]  op_code,
    output logic [4:0]  out_rd,
    output logic        out_illegal
`ifdef ALU_DISPATCH_PERF_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_illegal
`endif
);

    alu_entry_t dec;
    alu_entry_t out_entry;
    logic       is_custom0;
    logic       unused_instr_bits;

    assign is_custom0        = (in_instr[6:0] == CUSTOM0_OPCODE) && (in_instr[31:25] == 7'd0);
    assign unused_instr_bits = ^in_instr[24:15];

    always_comb begin
        dec         = '0;
        dec.rd      = in_instr[11:7];
        dec.op_code = OP_ILLEGAL;
        dec.illegal = 1'b1;
        if (is_custom0) begin
            dec.illegal   = 1'b0;
            dec.operand_a = in_rs1_val;
            dec.operand_b = in_rs2_val;
            case (in_instr[14:12])
                3'b000: dec.op_code = OP_ADD;
                3'b001: dec.op_code = OP_SUB;
                3'b010: dec.op_code = OP_AND;
                3'b011: dec.op_code = OP_OR;
                3'b100: dec.op_code = OP_POPCOUNT;
                3'b101: dec.op_code = OP_CLZ;
                default: begin
                    dec.op_code   = OP_ILLEGAL;
                    dec.illegal   = 1'b1;
                    dec.operand_a = '0;
                    dec.operand_b = '0;
                end
            endcase
            // Unary ops ignore rs2.
            if (dec.op_code == OP_POPCOUNT || dec.op_code == OP_CLZ) begin
                dec.operand_b = '0;
            end
        end
    end

    alu_dispatch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tvalid (in_valid),
        .s_tready (in_ready),
        .s_tdata  (dec),
        .m_tvalid (out_valid),
        .m_tready (out_ready),
        .m_tdata  (out_entry)
    );

    assign op_code     = out_entry.op_code;
    assign operand_a   = out_entry.operand_a;
    assign operand_b   = out_entry.operand_b;
    assign out_rd      = out_entry.rd;
    assign out_illegal = out_entry.illegal;

`ifdef ALU_DISPATCH_PERF_EN
    logic [31:0] perf_issued_q;
    logic [31:0] perf_illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q  <= '0;
            perf_illegal_q <= '0;
        end else if (out_valid && out_ready) begin
            perf_issued_q <= perf_issued_q + 32'd1;
            if (out_illegal) begin
                perf_illegal_q <= perf_illegal_q + 32'd1;
            end
        end
    end

    assign perf_issued  = perf_issued_q;
    assign perf_illegal = perf_illegal_q;
`endif

endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning decoded-entry buffer depth (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-005 SHALL have port in_ready  output  1  buffer can accept this cycle.
REQ-006 SHALL have port in_instr  input  32  RISC-V instruction word.
REQ-007 SHALL have port in_rs1_val  input  32  rs1 register value.
REQ-008 SHALL have port in_rs2_val  input  32  rs2 register value.
REQ-009 SHALL have port out_valid  output  1  decoded entry presented to ALU.
REQ-010 SHALL have port out_ready  input  1  downstream consumes entry.
REQ-011 SHALL have ports operand_a, operand_b  output  32 each  ALU operands.
REQ-012 SHALL have port op_code  output  4  ALU operation select.
REQ-013 SHALL have port out_rd  output  5  destination register tag, instr[11:7].
REQ-014 SHALL have port out_illegal  output  1  entry failed decode.

Function
REQ-015 SHALL accept an entry when in_valid && in_ready; SHALL pop when out_valid && out_ready.
REQ-016 SHALL decode only opcode instr[6:0]=7'b0001011 with funct7 instr[31:25]=0: funct3 000->4'b0000 ADD, 001->4'b0001 SUB, 010->4'b0010 AND, 011->4'b0011 OR, 100->4'b0100 POPCOUNT, 101->4'b0101 CLZ.
REQ-017 SHALL, for any other encoding, store op_code=4'b1111, out_illegal=1, operands=0; illegal entries flow through, never dropped.
REQ-018 SHALL force operand_b=0 for POPCOUNT and CLZ; operand_a=in_rs1_val, operand_b=in_rs2_val otherwise.
REQ-019 SHALL decode combinationally at input and store decoded fields; latency accept->out_valid exactly 1 cycle when empty.
REQ-020 SHALL keep in-order FIFO semantics; occupancy counter 0..DEPTH, read/write pointers wrap modulo DEPTH.
REQ-021 SHALL drive in_ready = (count < DEPTH) from registered state only; no combinational path out_ready->in_ready.
REQ-022 SHALL, on simultaneous push and pop with 0<count<DEPTH, keep count unchanged; at count=DEPTH no push occurs.
REQ-023 SHALL hold out_* stable while out_valid && !out_ready.
REQ-024 SHALL drive out_valid = (count != 0); payload outputs are don't-care but SHALL read 0 when empty.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear count, pointers and counters: out_valid=0, in_ready=1 after release, payload outputs 0, op_code 4'b0000.
REQ-026 SHALL discard all buffered entries on reset asserted mid-operation; no entry emitted after release until a new accept.

Configuration
REQ-027 SHALL, with ALU_DISPATCH_PERF_EN defined, add outputs perf_issued[31:0] (pops) and perf_illegal[31:0] (pops with out_illegal=1), both wrap at 2^32, reset to 0.
REQ-028 SHALL, without ALU_DISPATCH_PERF_EN, omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-029 SHALL place in shared package alu_pkg: op_code enum (ADD..CLZ, ILLEGAL=4'b1111), CUSTOM0_OPCODE=7'b0001011 constant, decoded-entry struct {op_code, operand_a, operand_b, rd, illegal}.
REQ-030 SHALL implement storage as one sub-module alu_dispatch_fifo (parameterised by DEPTH, entry type from alu_pkg); decode stays in alu_dispatch.

Verification
REQ-031 SHALL cover: instr 0x0020818B (funct3 000, rd=3), rs1=5, rs2=7 -> next cycle out_valid=1, op_code=0000, operands 5/7, out_rd=3.
REQ-032 SHALL cover: POPCOUNT (funct3 100), rs1=0xF0F0_F0F0, rs2=0x1234 -> op_code=0100, operand_b=0.
REQ-033 SHALL cover: instr 0x00000033 (base OP) -> out_illegal=1, op_code=1111, operands 0; perf_illegal increments by 1 on pop when macro defined.
REQ-034 SHALL cover: out_ready=0, push 3 entries at DEPTH=2 -> in_ready=0 after second accept, third held; release out_ready -> entries emerge in order, payload stable while stalled.
REQ-035 SHALL cover: rst_n low for 1 cycle with 2 entries buffered -> out_valid=0 immediately, in_ready=1 after release, no stale entry emitted.
